// File: rtl/stream_mux_pkg.sv
// stream_mux_pkg: shared constants and helpers for the stream_mux_rr block.
//   MODE_FIXED / MODE_RR : values of the mode input
//   STATS_W              : width of the optional transfer counter
//   rr_idx()             : rotate-priority search index (base + off) mod n
package stream_mux_pkg;

  localparam logic MODE_FIXED = 1'b0;
  localparam logic MODE_RR    = 1'b1;

  localparam int unsigned STATS_W = 16;

  // Index of the off-th candidate when searching upward from base, wrapping at n.
  function automatic int unsigned rr_idx(input int unsigned base, input int unsigned off,
                                         input int unsigned n);
    return (base + off) % n;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: purely combinational rotate-priority arbiter.
// Ports:
//   req_i       [NUM_CH]  request vector
//   ptr_i       [SEL_W]   highest-priority channel for this cycle
//   en_i                  enable; grant is zero when low
//   grant_o     [NUM_CH]  one-hot grant (or zero)
//   grant_idx_o [SEL_W]   encoded index of the granted channel (0 when none)
// The pointer register lives in the parent.
module rr_arbiter
  import stream_mux_pkg::*;
#(
  parameter int unsigned NUM_CH = 4,
  parameter int unsigned SEL_W  = $clog2(NUM_CH)
) (
  input  logic [NUM_CH-1:0] req_i,
  input  logic [SEL_W-1:0]  ptr_i,
  input  logic              en_i,
  output logic [NUM_CH-1:0] grant_o,
  output logic [SEL_W-1:0]  grant_idx_o
);

  logic             found;
  logic [SEL_W-1:0] idx;

  always_comb begin
    grant_o     = '0;
    grant_idx_o = '0;
    found       = 1'b0;
    idx         = '0;
    for (int unsigned off = 0; off < NUM_CH; off++) begin
      idx = SEL_W'(rr_idx(32'(ptr_i), off, NUM_CH));
      if (en_i && !found && req_i[idx]) begin
        grant_o[idx] = 1'b1;
        grant_idx_o  = idx;
        found        = 1'b1;
      end
    end
  end

endmodule

// File: rtl/stream_mux_rr.sv
// stream_mux_rr: N-channel registered stream multiplexer with valid/ready on every
// input and on the output. Fixed mode forwards the channel named by select; round-robin
// mode grants fairly among valid channels starting at an internal pointer.
// Ports:
//   clk, rst_n             clock, synchronous active-low reset
//   mode                   0 = fixed select, 1 = round-robin
//   select   [SEL_W]       channel used in fixed mode
//   in_data  [NUM_CH*WIDTH] channel i at [i*WIDTH +: WIDTH]
//   in_valid / in_ready    per-channel handshake (in_ready is combinational)
//   out_data / out_ch      registered output word and its source channel
//   out_valid / out_ready  output handshake
//   xfer_cnt [16]          accepted-transfer count, saturating (only with
//                          STREAM_MUX_RR_STATS_EN defined)
module stream_mux_rr
  import stream_mux_pkg::*;
#(
  parameter int unsigned NUM_CH = 4,
  parameter int unsigned WIDTH  = 4,
  parameter int unsigned SEL_W  = $clog2(NUM_CH)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    mode,
  input  logic [SEL_W-1:0]        select,
  input  logic [NUM_CH*WIDTH-1:0] in_data,
  input  logic [NUM_CH-1:0]       in_valid,
  output logic [NUM_CH-1:0]       in_ready,
  output logic [WIDTH-1:0]        out_data,
  output logic [SEL_W-1:0]        out_ch,
  output logic                    out_valid,
  input  logic                    out_ready
`ifdef STREAM_MUX_RR_STATS_EN
  ,
  output logic [STATS_W-1:0]      xfer_cnt
`endif
);

  logic [WIDTH-1:0]  out_data_q, out_data_d;
  logic [SEL_W-1:0]  out_ch_q, out_ch_d;
  logic              out_valid_q, out_valid_d;
  logic [SEL_W-1:0]  ptr_q, ptr_d;

  logic              load;
  logic              xfer;
  logic [NUM_CH-1:0] grant, grant_fix, grant_rr;
  logic [SEL_W-1:0]  grant_idx, grant_idx_rr;
  logic [WIDTH-1:0]  sel_data;
  int unsigned       sel_int;

  // Output register can take a new word when empty or draining this cycle.
  assign load    = !out_valid_q | out_ready;
  assign sel_int = 32'(select);

  rr_arbiter #(
    .NUM_CH (NUM_CH),
    .SEL_W  (SEL_W)
  ) u_rr_arbiter (
    .req_i       (in_valid),
    .ptr_i       (ptr_q),
    .en_i        (mode == MODE_RR),
    .grant_o     (grant_rr),
    .grant_idx_o (grant_idx_rr)
  );

  // An out-of-range select (non power-of-two NUM_CH) grants nothing.
  always_comb begin
    grant_fix = '0;
    if (sel_int < NUM_CH) begin
      grant_fix[select] = in_valid[select];
    end
  end

  assign grant     = (mode == MODE_RR) ? grant_rr : grant_fix;
  assign grant_idx = (mode == MODE_RR) ? grant_idx_rr : select;
  assign in_ready  = rst_n ? (grant & {NUM_CH{load}}) : '0;
  // in_ready implies in_valid via the grant, so any ready bit is a handshake.
  assign xfer      = |in_ready;

  always_comb begin
    sel_data = '0;
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      if (grant[i]) begin
        sel_data = in_data[i*WIDTH +: WIDTH];
      end
    end
  end

  always_comb begin
    out_data_d  = out_data_q;
    out_ch_d    = out_ch_q;
    out_valid_d = out_valid_q;
    ptr_d       = ptr_q;
    if (xfer) begin
      out_data_d  = sel_data;
      out_ch_d    = grant_idx;
      out_valid_d = 1'b1;
      if (mode == MODE_RR) begin
        ptr_d = SEL_W'(rr_idx(32'(grant_idx), 1, NUM_CH));
      end
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_data_q  <= '0;
      out_ch_q    <= '0;
      out_valid_q <= 1'b0;
      ptr_q       <= '0;
    end else begin
      out_data_q  <= out_data_d;
      out_ch_q    <= out_ch_d;
      out_valid_q <= out_valid_d;
      ptr_q       <= ptr_d;
    end
  end

  assign out_data  = out_data_q;
  assign out_ch    = out_ch_q;
  assign out_valid = out_valid_q;

`ifdef STREAM_MUX_RR_STATS_EN
  logic [STATS_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (xfer && (cnt_q != '1)) begin
      cnt_d = cnt_q + STATS_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign xfer_cnt = cnt_q;
`endif

endmodule

// File: tb/tb_stream_mux_rr.sv
module tb_stream_mux_rr;

  localparam int unsigned NUM_CH = 4;
  localparam int unsigned WIDTH  = 4;
  localparam int unsigned SEL_W  = 2;

  logic                    clk;
  logic                    rst_n;
  logic                    mode;
  logic [SEL_W-1:0]        select;
  logic [NUM_CH*WIDTH-1:0] in_data;
  logic [NUM_CH-1:0]       in_valid;
  logic [NUM_CH-1:0]       in_ready;
  logic [WIDTH-1:0]        out_data;
  logic [SEL_W-1:0]        out_ch;
  logic                    out_valid;
  logic                    out_ready;
`ifdef STREAM_MUX_RR_STATS_EN
  logic [15:0]             xfer_cnt;
`endif

  int checks;
  int failures;

  stream_mux_rr #(
    .NUM_CH (NUM_CH),
    .WIDTH  (WIDTH)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .mode      (mode),
    .select    (select),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_data  (out_data),
    .out_ch    (out_ch),
    .out_valid (out_valid),
    .out_ready (out_ready)
`ifdef STREAM_MUX_RR_STATS_EN
    ,
    .xfer_cnt  (xfer_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      $error("%s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one clock edge; sampling happens 1 time unit after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    checks    = 0;
    failures  = 0;
    rst_n     = 1'b0;
    mode      = 1'b0;
    select    = 2'd0;
    in_data   = 16'h3210;
    in_valid  = 4'h0;
    out_ready = 1'b1;
    step();
    step();

    // Reset state; in_ready forced low while in reset even with valid inputs.
    in_valid = 4'hF;
    #1;
    check("rst_in_ready", 32'(in_ready), 32'h0);
    check("rst_out_valid", 32'(out_valid), 32'h0);
    check("rst_out_data", 32'(out_data), 32'h0);
    check("rst_out_ch", 32'(out_ch), 32'h0);

    // Fixed mode, select stepping 0..3.
    rst_n = 1'b1;
    for (int s = 0; s < 4; s++) begin
      select = SEL_W'(s);
      #1;
      check("fix_in_ready", 32'(in_ready), 32'(1 << s));
      step();
      check("fix_out_data", 32'(out_data), 32'(s));
      check("fix_out_ch", 32'(out_ch), 32'(s));
      check("fix_out_valid", 32'(out_valid), 32'h1);
    end

    // select=3 with channel 3 idle: no transfer, output drains, data held.
    in_valid = 4'b0111;
    #1;
    check("idle_sel_in_ready", 32'(in_ready), 32'h0);
    step();
    check("idle_sel_drain_valid", 32'(out_valid), 32'h0);
    check("idle_sel_hold_data", 32'(out_data), 32'h3);

    // Round-robin, all valid: pointer still 0 from reset (held in fixed mode).
    mode     = 1'b1;
    in_valid = 4'hF;
    for (int k = 0; k < 6; k++) begin
      step();
      check("rr_all_out_ch", 32'(out_ch), 32'(k % 4));
      check("rr_all_out_data", 32'(out_data), 32'(k % 4));
      check("rr_all_out_valid", 32'(out_valid), 32'h1);
    end

    // Round-robin, channels 1 and 3 only; pointer is 2 so channel 3 goes first.
    in_valid = 4'b1010;
    for (int k = 0; k < 4; k++) begin
      #1;
      check("rr_13_no_ready_0_2", 32'(in_ready & 4'b0101), 32'h0);
      step();
      check("rr_13_out_ch", 32'(out_ch), (k % 2 == 0) ? 32'h3 : 32'h1);
    end

    // Backpressure with data 2 held.
    mode     = 1'b0;
    select   = 2'd2;
    in_valid = 4'hF;
    step();
    check("bp_load_data", 32'(out_data), 32'h2);
    out_ready = 1'b0;
    select    = 2'd3;
    for (int k = 0; k < 3; k++) begin
      #1;
      check("bp_in_ready", 32'(in_ready), 32'h0);
      step();
      check("bp_hold_data", 32'(out_data), 32'h2);
      check("bp_hold_ch", 32'(out_ch), 32'h2);
      check("bp_hold_valid", 32'(out_valid), 32'h1);
    end
    out_ready = 1'b1;
    #1;
    check("bp_release_ready", 32'(in_ready), 32'h8);
    step();
    check("bp_next_data", 32'(out_data), 32'h3);
    check("bp_next_ch", 32'(out_ch), 32'h3);
    in_valid = 4'h0;
    step();
    check("bp_no_dup_valid", 32'(out_valid), 32'h0);

    // Reset mid-operation with a pending word; pointer (currently 2) returns to 0.
    in_valid = 4'hF;
    select   = 2'd1;
    step();
    check("mid_pre_valid", 32'(out_valid), 32'h1);
    check("mid_pre_data", 32'(out_data), 32'h1);
    rst_n = 1'b0;
    step();
    check("mid_rst_valid", 32'(out_valid), 32'h0);
    check("mid_rst_data", 32'(out_data), 32'h0);
    check("mid_rst_ch", 32'(out_ch), 32'h0);
    rst_n = 1'b1;
    mode  = 1'b1;
    #1;
    check("post_rst_rr_ready", 32'(in_ready), 32'h1);

    // Six round-robin transfers after reset: channels 0,1,2,3,0,1.
    for (int k = 0; k < 6; k++) begin
      step();
      check("post_rst_rr_ch", 32'(out_ch), 32'(k % 4));
    end
    in_valid = 4'h0;
    step();
    check("post_rst_drain", 32'(out_valid), 32'h0);
`ifdef STREAM_MUX_RR_STATS_EN
    check("stats_count6", 32'(xfer_cnt), 32'd6);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/stream_mux_rr.md
Name: stream_mux_rr

Overview:
Parametrised N-channel, W-bit registered stream multiplexer with a valid/ready handshake on every input and on the output. It is the successor to the team's combinational 4:1 select mux. It adds two selection modes: fixed (an external select picks the channel) and round-robin (a fair arbiter picks among valid channels). It sits between several producer blocks and a single consumer, and has a registered output for timing closure.

Parameters:
NUM_CH, 4, number of input channels (>=2)
WIDTH, 4, data width per channel in bits
SEL_W, $clog2(NUM_CH), width of select and channel-id fields (derived; do not override)

Ports:
clk  in  1  single system clock, rising edge
rst_n  in  1  reset; synchronous, active-low
mode  in  1  0 = fixed select, 1 = round-robin
select  in  SEL_W  channel index used in fixed mode
in_data  in  NUM_CH*WIDTH  flattened channel data; channel i at [i*WIDTH +: WIDTH]
in_valid  in  NUM_CH  per-channel valid
in_ready  out  NUM_CH  per-channel ready (combinational)
out_data  out  WIDTH  registered output data
out_ch  out  SEL_W  index of the channel that produced out_data
out_valid  out  1  output holds valid data
out_ready  in  1  consumer accepts when high with out_valid

Behaviour:
- Reset (rst_n low at a clk edge): out_valid=0, out_data=0, out_ch=0, rr pointer=0. in_ready is forced to all-0 while rst_n is low.
- Load enable: load = !out_valid | out_ready.
- Grant (combinational, one-hot or zero):
  - Fixed mode: grant[select] = in_valid[select].
  - Round-robin mode: grant goes to the first valid channel searching from the pointer upward, wrapping NUM_CH-1 -> 0.
- Ready: in_ready[i] = grant[i] & load. At most one bit is high per cycle. in_ready never depends on out_valid of the same channel beyond this rule.
- Transfer: when in_valid[i] & in_ready[i], then on the next edge out_data <= channel i data, out_ch <= i, out_valid <= 1. Latency is 1 cycle input-to-output.
- Output hold: when out_valid & !out_ready, out_data, out_ch and out_valid are held stable. No input is accepted in this case.
- Output drain: when out_valid & out_ready and no input grant, out_valid <= 0. out_data/out_ch keep their last value.
- Simultaneous drain and accept: back-to-back throughput of 1 transfer/cycle.
- Pointer: in round-robin mode, after an accepted transfer from channel i, pointer <= (i+1) mod NUM_CH. Wrap from NUM_CH-1 goes to 0. The pointer holds in fixed mode and on cycles with no transfer.
- select >= NUM_CH (non-power-of-2 NUM_CH): no grant; all in_ready stay 0.
- Mode or select change: takes effect on the same cycle for the grant. An already-registered output is unaffected.
- Reset mid-operation: any pending output word is discarded; no handshake completes on the reset edge.

Optional Feature:
Macro STREAM_MUX_RR_STATS_EN.
- Defined: adds output port xfer_cnt [15:0], a count of accepted input transfers.
  - Reset value 0.
  - +1 per input handshake.
  - Saturates at 16'hFFFF with no wrap.
- Undefined: the port and counter are absent. All other behaviour is identical.

Decomposition:
- Package stream_mux_pkg: mode constants MODE_FIXED=1'b0 and MODE_RR=1'b1; function for the rotate-priority search index; stats counter width constant (16).
- Sub-module rr_arbiter (NUM_CH): inputs req, ptr, en; outputs one-hot grant and encoded grant index. It is purely combinational; the pointer register stays in the parent.

Test Plan:
- Fixed mode, NUM_CH=4, WIDTH=4, channel i data = i, all valid, out_ready=1, select stepping 0,1,2,3 every cycle -> out_data 0,1,2,3 each one cycle later; out_ch matches; in_ready one-hot on the selected channel.
- Round-robin mode, all four channels valid continuously, out_ready=1 -> out_ch sequence 0,1,2,3,0,1 at 1 word/cycle; pointer wraps 3->0.
- Round-robin mode, only channels 1 and 3 valid -> out_ch alternates 1,3,1,3; channels 0 and 2 never see in_ready.
- Backpressure: out_ready=0 for 3 cycles with out_valid=1 (data 2) -> out_data stays 2, all in_ready=0. Release -> next word appears the following cycle with no loss or duplication.
- Reset: rst_n low for one edge while out_valid=1 -> out_valid=0, out_data=0, out_ch=0. The first round-robin grant after reset goes to channel 0.
- Edge cases: select=3 with in_valid[3]=0 -> no transfer and out_valid drops after drain. With STREAM_MUX_RR_STATS_EN, 6 transfers -> xfer_cnt=6; with the counter preloaded near 16'hFFFF, it saturates at 16'hFFFF.
